// File: rtl/swap_buffer.sv
// Ping-pong frame buffer: back bank takes writes/clears, front bank is read by the display.
// Define SWAP_BUFFER_DEPTH_TEST_EN for compare-and-write (z-buffer) writes with a DRAIN state.
module swap_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr_write,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      clear_value,
  input  logic                  swap,
  input  logic [ADDR_WIDTH-1:0] addr_read,
  output logic [WIDTH-1:0]      data_out,
  output logic                  ready,
  output logic                  front_bank,
  output logic                  swap_pending,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

`ifdef SWAP_BUFFER_DEPTH_TEST_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEARING = 2'd1, S_DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEARING = 2'd1} state_t;
`endif

  state_t                state_q, state_d;
  logic                  front_q, front_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      cval_q, cval_d;
  logic [WIDTH-1:0]      dout_q;
  logic [WIDTH-1:0]      mem_q [2][DEPTH];

  logic                  mem_we;
  logic                  mem_bank;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  wr_ok, rd_ok;

  assign wr_ok = ({1'b0, addr_write} < DEPTH_W);
  assign rd_ok = ({1'b0, addr_read} < DEPTH_W);

`ifdef SWAP_BUFFER_DEPTH_TEST_EN
  logic                  s2_valid_q, s2_bank_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q;
  logic [WIDTH-1:0]      s2_data_q, s2_rd_q, s2_cur;
  logic                  fwd_valid_q, fwd_bank_q;
  logic [ADDR_WIDTH-1:0] fwd_addr_q;
  logic [WIDTH-1:0]      fwd_val_q;
  logic                  s2_wr;
  logic                  drain_swap_q, drain_swap_d, drain_clear_q, drain_clear_d;

  // The stage-1 read cannot see the write retiring on the same edge, so forward it.
  assign s2_cur = (fwd_valid_q && fwd_addr_q == s2_addr_q && fwd_bank_q == s2_bank_q)
                  ? fwd_val_q : s2_rd_q;
  assign s2_wr  = s2_valid_q && (s2_data_q < s2_cur);
`endif

  // ready=1 means write_enable/clear/swap presented this cycle are taken at the next edge;
  // when ready=0 writes and clears are dropped and a swap is only remembered during CLEARING.
  assign ready        = (state_q == S_IDLE);
  assign front_bank   = front_q;
  assign swap_pending = pend_q;
  assign data_out     = dout_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    cval_d    = cval_q;
    mem_we    = 1'b0;
    mem_bank  = ~front_q;
    mem_addr  = addr_write;
    mem_wdata = data_in;
`ifdef SWAP_BUFFER_DEPTH_TEST_EN
    drain_swap_d  = drain_swap_q;
    drain_clear_d = drain_clear_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef SWAP_BUFFER_DEPTH_TEST_EN
        if ((swap || clear) && s2_valid_q) begin
          state_d       = S_DRAIN;
          drain_swap_d  = swap;
          drain_clear_d = clear;
          if (clear) cval_d = clear_value;
        end else begin
`else
        begin
          mem_we = write_enable && wr_ok;
`endif
          if (swap) front_d = ~front_q;
          if (clear) begin
            state_d = S_CLEARING;
            cnt_d   = '0;
            cval_d  = clear_value;
          end
        end
      end
      S_CLEARING: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = cval_q;
        if (swap) pend_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
          if (pend_q || swap) front_d = ~front_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SWAP_BUFFER_DEPTH_TEST_EN
      S_DRAIN: begin
        if (drain_swap_q) front_d = ~front_q;
        if (drain_clear_q) begin
          state_d = S_CLEARING;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef SWAP_BUFFER_DEPTH_TEST_EN
    if (s2_wr && state_q != S_CLEARING) begin
      mem_we    = 1'b1;
      mem_bank  = s2_bank_q;
      mem_addr  = s2_addr_q;
      mem_wdata = s2_data_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      cval_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      cval_q  <= cval_d;
      dout_q  <= rd_ok ? mem_q[front_q][addr_read] : '0;
    end
  end

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_bank][mem_addr] <= mem_wdata;
`ifdef SWAP_BUFFER_DEPTH_TEST_EN
    if (wr_ok) s2_rd_q <= mem_q[~front_q][addr_write];
`endif
  end

`ifdef SWAP_BUFFER_DEPTH_TEST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q    <= 1'b0;
      s2_bank_q     <= 1'b0;
      s2_addr_q     <= '0;
      s2_data_q     <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_bank_q    <= 1'b0;
      fwd_addr_q    <= '0;
      fwd_val_q     <= '0;
      drain_swap_q  <= 1'b0;
      drain_clear_q <= 1'b0;
    end else begin
      s2_valid_q    <= (state_q == S_IDLE) && write_enable && wr_ok;
      s2_bank_q     <= ~front_q;
      s2_addr_q     <= addr_write;
      s2_data_q     <= data_in;
      fwd_valid_q   <= s2_valid_q;
      fwd_bank_q    <= s2_bank_q;
      fwd_addr_q    <= s2_addr_q;
      fwd_val_q     <= s2_wr ? s2_data_q : s2_cur;
      drain_swap_q  <= drain_swap_d;
      drain_clear_q <= drain_clear_d;
    end
  end
`endif

endmodule
